// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ producers.
// Grants bursts of up to MAX_BURST beats; every beat is gated by wfull.
module fifo_wr_arbiter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BURST  = 4,
   localparam int unsigned OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          wclk,
   input  logic                          wrst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            gnt,
   output logic                          winc,
   output logic [DATA_WIDTH-1:0]         wdata,
   input  logic                          wfull,
   output logic                          busy,
   output logic [OW-1:0]                 owner
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e        state_q, state_d;
   logic [OW-1:0] owner_q, owner_d;
   logic [OW-1:0] last_q, last_d;
   logic [7:0]    beat_cnt_q, beat_cnt_d;

   logic          sel_found;
   logic [OW-1:0] sel_idx;
   logic          beat;

   // Search starts just after the previous owner, so it has lowest priority.
   always_comb begin
      int unsigned   cand;
      logic [OW-1:0] cand_idx;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         cand     = (32'(last_q) + k) % NUM_REQ;
         cand_idx = OW'(cand);
         if (!sel_found && req[cand_idx]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      beat_cnt_d = beat_cnt_q;
      beat       = 1'b0;
      gnt        = '0;
      unique case (state_q)
         StIdle: begin
            if (sel_found) begin
               state_d    = StGrant;
               owner_d    = sel_idx;
               last_d     = sel_idx;
               beat_cnt_d = '0;
            end
         end
         StGrant: begin
            beat         = req[owner_q] & ~wfull;
            gnt[owner_q] = beat;
            if (!req[owner_q]) begin
               state_d = StIdle;
            end else if (beat) begin
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BURST)) begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign winc  = beat;
   assign busy  = (state_q == StGrant);
   assign owner = owner_q;
   assign wdata = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         last_q     <= OW'(NUM_REQ - 1);
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         last_q     <= last_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter: cycle-level round-robin reference model,
// directed burst/rotation/reset checks and a starvation bound.
module tb_fifo_wr_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned MB = 4;

   logic            wclk = 1'b0;
   logic            wrst_n;
   logic [N-1:0]    req;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    gnt;
   logic            winc;
   logic [DW-1:0]   wdata;
   logic            wfull;
   logic            busy;
   logic [1:0]      owner;

   fifo_wr_arbiter #(
      .DATA_WIDTH(DW),
      .NUM_REQ   (N),
      .MAX_BURST (MB)
   ) dut (
      .wclk    (wclk),
      .wrst_n  (wrst_n),
      .req     (req),
      .req_data(req_data),
      .gnt     (gnt),
      .winc    (winc),
      .wdata   (wdata),
      .wfull   (wfull),
      .busy    (busy),
      .owner   (owner)
   );

   always #5 wclk = ~wclk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference: who holds the port and how many beats it still may take.
   bit m_busy;
   int m_owner;
   int m_last;
   int m_left;
   int wait_cnt [N];
   int max_wait;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      m_owner = 0;
      m_last  = N - 1;
      m_left  = 0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
   endtask

   // Compare settled outputs against the model, then advance the model one edge.
   task automatic step_check();
      bit            exp_beat;
      logic [N-1:0]  exp_gnt;
      logic [DW-1:0] exp_data;
      exp_beat = m_busy && req[m_owner] && !wfull;
      exp_gnt  = '0;
      if (exp_beat) exp_gnt[m_owner] = 1'b1;
      check_val("gnt", 32'(gnt), 32'(exp_gnt));
      check_val("winc", 32'(winc), 32'(exp_beat));
      check_val("busy", 32'(busy), 32'(m_busy));
      if (m_busy) check_val("owner", 32'(owner), 32'(m_owner));
      if (exp_beat) begin
         exp_data = req_data[m_owner*DW +: DW];
         check_val("wdata", 32'(wdata), 32'(exp_data));
      end
      if (winc) check_val("winc_while_full", 32'(wfull), 32'd0);
      for (int i = 0; i < N; i++) begin
         if (req[i] && !wfull && !gnt[i]) wait_cnt[i]++;
         else wait_cnt[i] = 0;
         if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
      end
      if (!m_busy) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (!m_busy && req[c]) begin
               m_busy  = 1'b1;
               m_owner = c;
               m_last  = c;
               m_left  = MB;
            end
         end
      end else if (!req[m_owner]) begin
         m_busy = 1'b0;
      end else if (!wfull) begin
         m_left--;
         if (m_left == 0) m_busy = 1'b0;
      end
   endtask

   task automatic tick();
      #1;
      step_check();
      @(negedge wclk);
   endtask

   logic [9:0]   pat;
   logic [N-1:0] prev_gnt;
   int           beat_no;
   int           full_pct;

   initial begin
      wrst_n   = 1'b0;
      req      = '0;
      req_data = '0;
      wfull    = 1'b0;
      max_wait = 0;
      model_reset();
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;

      // Idle with no requests.
      for (int c = 0; c < 10; c++) tick();

      // Single requester: 1 idle, 4 beats, 1 idle, 4 beats.
      pat = 10'b11110_11110;
      req = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         req_data[7:0] = 8'h10 + 8'(c);
         #1;
         check_val("t2_gnt0", 32'(gnt[0]), 32'(pat[c]));
         if (pat[c]) check_val("t2_wdata", 32'(wdata), 32'h10 + 32'(c));
         step_check();
         @(negedge wclk);
      end
      req = '0;
      tick();

      // Asynchronous reset while mid-burst.
      req = 4'b0100;
      tick();
      tick();
      #2;
      wrst_n = 1'b0;
      #1;
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_winc", 32'(winc), 32'd0);
      check_val("arst_gnt", 32'(gnt), 32'd0);
      model_reset();
      req = '0;
      @(negedge wclk);
      wrst_n = 1'b1;
      tick();

      // All requesting: owners 0,1,2,3,0 with 4 beats each.
      req     = 4'b1111;
      beat_no = 0;
      for (int c = 0; c < 25; c++) begin
         for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'((i << 4) | (c & 15));
         #1;
         if (winc) begin
            check_val("t3_owner_seq", 32'(owner), 32'((beat_no / MB) % N));
            beat_no++;
         end
         step_check();
         @(negedge wclk);
      end
      check_val("t3_words", 32'(beat_no), 32'd20);
      req = '0;
      tick();

      // Random requests with phases of varying FIFO fullness.
      max_wait = 0;
      prev_gnt = '0;
      for (int c = 0; c < 9000; c++) begin
         full_pct = ((c / 1000) % 3 == 0) ? 0 : (((c / 1000) % 3 == 1) ? 15 : 50);
         for (int i = 0; i < N; i++) begin
            if (!(req[i] && !prev_gnt[i] && ($urandom % 8 != 0))) begin
               req[i]               = 1'($urandom % 2);
               req_data[i*DW +: DW] = 8'($urandom);
            end
         end
         wfull = ($urandom % 100) < 32'(full_pct);
         #1;
         prev_gnt = gnt;
         step_check();
         @(negedge wclk);
      end
      check_val("starvation_bound", 32'(max_wait <= int'(N * (MB + 1))), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
